// File: rtl/line_job_pkg.sv
// line_job_pkg: shared types for the line job sequencer slice.
package line_job_pkg;
    localparam int COORD_W = 11;

    typedef struct packed {
        logic [COORD_W-1:0] x0;
        logic [COORD_W-1:0] y0;
        logic [COORD_W-1:0] x1;
        logic [COORD_W-1:0] y1;
        logic               color;
    } line_cmd_t;

    typedef enum logic [1:0] {IDLE, LAUNCH, DRAW, CLEAR} ljs_state_t;
endpackage

// File: rtl/line_job_sequencer_cmd_fifo.sv
// cmd_fifo: show-ahead synchronous FIFO of line commands with a synchronous flush.
module cmd_fifo
    import line_job_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic      clock,
    input  logic      reset,
    input  logic      flush_i,
    input  logic      push_i,
    input  logic      pop_i,
    input  line_cmd_t push_data_i,
    output line_cmd_t head_o,
    output logic      full_o,
    output logic      empty_o
);
    localparam int AW = $clog2(DEPTH);

    line_cmd_t     mem_q [DEPTH];
    logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic          do_push, do_pop;

    assign full_o  = cnt_q[AW];
    assign empty_o = cnt_q == '0;
    assign do_pop  = pop_i && !empty_o;
    // a pop frees the slot being written, so push-while-full is safe alongside a pop
    assign do_push = push_i && (!full_o || do_pop);
    assign head_o  = mem_q[rd_q];

    always_comb begin
        wr_d  = flush_i ? '0 : wr_q + AW'(do_push);
        rd_d  = flush_i ? '0 : rd_q + AW'(do_pop);
        cnt_d = flush_i ? '0 : cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clock) begin
        if (do_push && !flush_i) mem_q[wr_q] <= push_data_i;
    end
endmodule

// File: rtl/line_job_sequencer.sv
// line_job_sequencer: queues line commands for line_drawer and arbitrates the framebuffer write port with a clear scan.
// Define LJS_FLUSH_ON_CLEAR_EN to drop queued commands on entering CLEAR and refuse commands during it.
module line_job_sequencer
    import line_job_pkg::*;
#(
    parameter int DEPTH    = 4,
    parameter int SCREEN_W = 640,
    parameter int SCREEN_H = 480
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [COORD_W-1:0] cmd_x0,
    input  logic [COORD_W-1:0] cmd_y0,
    input  logic [COORD_W-1:0] cmd_x1,
    input  logic [COORD_W-1:0] cmd_y1,
    input  logic               cmd_color,
    input  logic               clear_req,
    output logic               ld_start,
    output logic [COORD_W-1:0] ld_x0,
    output logic [COORD_W-1:0] ld_y0,
    output logic [COORD_W-1:0] ld_x1,
    output logic [COORD_W-1:0] ld_y1,
    input  logic               ld_pix_valid,
    input  logic [COORD_W-1:0] ld_x,
    input  logic [COORD_W-1:0] ld_y,
    input  logic               ld_done,
    output logic [COORD_W-1:0] fb_x,
    output logic [COORD_W-1:0] fb_y,
    output logic               fb_color,
    output logic               fb_write,
    output logic               busy
);
    ljs_state_t         state_q, state_d;
    line_cmd_t          ld_q, ld_d, head, in_cmd;
    logic               pend_q, pend_d;
    logic [COORD_W-1:0] cx_q, cx_d, cy_q, cy_d;
    logic               full, empty, push, pop, flush, x_end, last;

    assign in_cmd = {cmd_x0, cmd_y0, cmd_x1, cmd_y1, cmd_color};
    assign x_end  = cx_q == COORD_W'(SCREEN_W - 1);
    assign last   = state_q == CLEAR && x_end && cy_q == COORD_W'(SCREEN_H - 1);
    assign push   = cmd_valid && cmd_ready;
    assign pop    = state_q == LAUNCH;
`ifdef LJS_FLUSH_ON_CLEAR_EN
    assign flush  = state_q == IDLE && pend_q;
`else
    assign flush  = 1'b0;
`endif

    cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clock      (clock),
        .reset      (reset),
        .flush_i    (flush),
        .push_i     (push),
        .pop_i      (pop),
        .push_data_i(in_cmd),
        .head_o     (head),
        .full_o     (full),
        .empty_o    (empty)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            ld_q    <= '0;
            pend_q  <= 1'b0;
            cx_q    <= '0;
            cy_q    <= '0;
        end else begin
            state_q <= state_d;
            ld_q    <= ld_d;
            pend_q  <= pend_d;
            cx_q    <= cx_d;
            cy_q    <= cy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    state_d = pend_q ? CLEAR : (!empty ? LAUNCH : IDLE);
            LAUNCH:  state_d = DRAW;
            DRAW:    state_d = ld_done ? IDLE : DRAW;
            CLEAR:   state_d = last ? IDLE : CLEAR;
        endcase
        // head is captured on the way into LAUNCH so ld_* is already valid while ld_start is high
        ld_d   = (state_q == IDLE && !pend_q && !empty) ? head : ld_q;
        pend_d = !last && (pend_q || clear_req);
        cx_d   = (state_q != CLEAR || x_end) ? '0 : cx_q + 1'b1;
        cy_d   = (state_q != CLEAR || last) ? '0 : (x_end ? cy_q + 1'b1 : cy_q);
    end

    always_comb begin
        ld_start = state_q == LAUNCH;
        fb_write = state_q == CLEAR || (state_q == DRAW && ld_pix_valid);
        fb_x     = state_q == CLEAR ? cx_q : (state_q == DRAW ? ld_x : '0);
        fb_y     = state_q == CLEAR ? cy_q : (state_q == DRAW ? ld_y : '0);
        fb_color = state_q == DRAW && ld_q.color;
        busy     = state_q != IDLE || !empty;
`ifdef LJS_FLUSH_ON_CLEAR_EN
        cmd_ready = !full && state_q != CLEAR;
`else
        cmd_ready = !full;
`endif
    end

    assign ld_x0 = ld_q.x0;
    assign ld_y0 = ld_q.y0;
    assign ld_x1 = ld_q.x1;
    assign ld_y1 = ld_q.y1;
endmodule

// File: tb/tb_line_job_sequencer.sv
// tb_line_job_sequencer: scoreboard bench with an emulated line_drawer and a raster model of the clear scan.
module tb_line_job_sequencer;
    localparam int DEPTH = 4;
    localparam int W     = 120;
    localparam int H     = 5;

    typedef struct packed {
        logic [10:0] x0;
        logic [10:0] y0;
        logic [10:0] x1;
        logic [10:0] y1;
        logic        c;
    } cmd_t;

    logic clock = 0;
    logic reset = 1;
    always #5 clock = ~clock;

    logic        cmd_valid = 0, cmd_color = 0, clear_req = 0, ld_pix_valid = 0, ld_done = 0;
    logic [10:0] cmd_x0 = 0, cmd_y0 = 0, cmd_x1 = 0, cmd_y1 = 0, ld_x = 0, ld_y = 0;
    logic        cmd_ready, ld_start, fb_color, fb_write, busy;
    logic [10:0] ld_x0, ld_y0, ld_x1, ld_y1, fb_x, fb_y;

    line_job_sequencer #(.DEPTH(DEPTH), .SCREEN_W(W), .SCREEN_H(H)) dut (
        .clock(clock), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_x0(cmd_x0), .cmd_y0(cmd_y0), .cmd_x1(cmd_x1), .cmd_y1(cmd_y1), .cmd_color(cmd_color),
        .clear_req(clear_req), .ld_start(ld_start), .ld_x0(ld_x0), .ld_y0(ld_y0), .ld_x1(ld_x1),
        .ld_y1(ld_y1), .ld_pix_valid(ld_pix_valid), .ld_x(ld_x), .ld_y(ld_y), .ld_done(ld_done),
        .fb_x(fb_x), .fb_y(fb_y), .fb_color(fb_color), .fb_write(fb_write), .busy(busy)
    );

    cmd_t        cq[$];
    logic [22:0] pq[$];
    cmd_t        mon_e;
    int          total = 0, bad = 0;
    bit          outstanding = 0, active = 0, cur_color = 0;
    int          rx = 0, ry = 0, clears_done = 0, lines_done = 0, last_start_clears = 0;
    int          stall_len = 0, spur_pct = 0, stall = 0, npix = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // monitor: every launch and every framebuffer write is checked against the scoreboard
    initial forever begin
        @(negedge clock);
        if (reset) begin
            cq.delete();
            pq.delete();
            outstanding = 0;
            rx = 0;
            ry = 0;
        end else begin
            if (ld_start) begin
                chk("launch_has_cmd", cq.size() > 0, 1);
                if (cq.size() > 0) begin
                    mon_e = cq.pop_front();
                    chk("launch_cmd", {ld_x0, ld_y0, ld_x1, ld_y1}, {mon_e.x0, mon_e.y0, mon_e.x1, mon_e.y1});
                    cur_color = mon_e.c;
                end
                last_start_clears = clears_done;
                lines_done++;
            end
            if (ld_pix_valid) begin
                chk("pix_write", fb_write, 1);
                chk("pix_expected", pq.size() > 0, 1);
                if (pq.size() > 0) chk("pix_data", {fb_x, fb_y, fb_color}, pq.pop_front());
            end else if (fb_write) begin
                chk("clear_expected", outstanding, 1);
                chk("clear_no_overlap", active, 0);
                chk("clear_pix", {fb_x, fb_y, fb_color}, {11'(rx), 11'(ry), 1'b0});
`ifdef LJS_FLUSH_ON_CLEAR_EN
                if (rx == 0 && ry == 0) cq.delete();
`endif
                if (rx == W - 1) begin
                    rx = 0;
                    if (ry == H - 1) begin
                        ry = 0;
                        outstanding = 0;
                        clears_done++;
                    end else ry++;
                end else rx++;
            end
        end
    end

    // emulated line_drawer: random stall, random pixel strobes, then ld_done; spurious ld_done when idle
    initial forever begin
        step();
        ld_pix_valid = 0;
        ld_done = 0;
        if (reset) active = 0;
        else if (ld_start) begin
            active = 1;
            stall = stall_len + int'($urandom_range(0, 3));
            npix = int'($urandom_range(1, 6));
        end else if (active) begin
            if (stall > 0) stall--;
            else if (npix > 0) begin
                if ($urandom_range(0, 3) != 0) begin
                    ld_pix_valid = 1;
                    ld_x = 11'($urandom);
                    ld_y = 11'($urandom);
                    pq.push_back({ld_x, ld_y, cur_color});
                    npix--;
                end
            end else begin
                ld_done = 1;
                active = 0;
            end
        end else if (int'($urandom_range(0, 99)) < spur_pct) ld_done = 1;
    end

    task automatic drive_cmd(input cmd_t c);
        cmd_valid = 1;
        {cmd_x0, cmd_y0, cmd_x1, cmd_y1, cmd_color} = c;
    endtask

    task automatic send(input cmd_t c);
        int t = 0;
        drive_cmd(c);
        while (!cmd_ready && t < 2000) begin
            step();
            t++;
        end
        chk("send_accepted", cmd_ready, 1);
        if (cmd_ready) cq.push_back(c);
        step();
        cmd_valid = 0;
    endtask

    task automatic pulse_clear();
        clear_req = 1;
        outstanding = 1;
        step();
        clear_req = 0;
    endtask

    task automatic wait_start(input string name);
        int t = 0;
        while (!ld_start && t < 500) begin
            step();
            t++;
        end
        chk(name, ld_start, 1);
    endtask

    task automatic wait_idle(input string name);
        int t = 0;
        while ((busy || active || outstanding || cq.size() != 0) && t < 20000) begin
            step();
            t++;
        end
        chk(name, t < 20000, 1);
        step();
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0, l0, t, spur_seen;
        cmd_t r;
        repeat (3) step();
        chk("rst_ready", cmd_ready, 1);
        chk("rst_start", ld_start, 0);
        chk("rst_write", fb_write, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ld", {ld_x0, ld_y0, ld_x1, ld_y1}, 0);
        chk("rst_fb", {fb_x, fb_y, fb_color}, 0);
        reset = 0;
        step();

        send('{x0: 11'd0, y0: 11'd0, x1: 11'd10, y1: 11'd0, c: 1'b1});
        step();
        chk("t1_start_latency", ld_start, 1);
        chk("t1_x0", ld_x0, 0);
        chk("t1_x1", ld_x1, 10);
        t = 0;
        while (!ld_done && t < 200) begin
            @(negedge clock);
            t++;
        end
        chk("t1_done_seen", ld_done, 1);
        chk("t1_busy_at_done", busy, 1);
        @(negedge clock);
        chk("t1_busy_after_done", busy, 0);
        step();

        l0 = lines_done;
        stall_len = 30;
        for (int i = 0; i < 5; i++) send(cmd_t'(45'({$urandom, $urandom})));
        chk("t2_full_ready", cmd_ready, 0);
        chk("t2_model_full", cq.size(), DEPTH);
        wait_start("t2_next_launch");
        chk("t2_ready_in_launch", cmd_ready, 0);
        step();
        chk("t2_ready_after_pop", cmd_ready, 1);
        send(cmd_t'(45'({$urandom, $urandom})));
        stall_len = 0;
        wait_idle("t2_idle");
        chk("t2_lines", lines_done - l0, 6);

        c0 = clears_done;
        l0 = lines_done;
        stall_len = 20;
        send('{x0: 11'd0, y0: 11'd0, x1: 11'd30, y1: 11'd10, c: 1'b1});
        wait_start("t3_launch");
        step();
        pulse_clear();
        send('{x0: 11'd5, y0: 11'd6, x1: 11'd7, y1: 11'd8, c: 1'b0});
        stall_len = 0;
        wait_idle("t3_idle");
        chk("t3_clears", clears_done - c0, 1);
`ifdef LJS_FLUSH_ON_CLEAR_EN
        chk("t3_lines", lines_done - l0, 1);
`else
        chk("t3_lines", lines_done - l0, 2);
        chk("t3_line_after_clear", last_start_clears, c0 + 1);
`endif

        c0 = clears_done;
        pulse_clear();
        repeat (4) step();
        pulse_clear();
        wait_idle("t4_idle");
        repeat (20) step();
        chk("t4_one_clear", clears_done - c0, 1);

        pulse_clear();
        t = 0;
        while (!(fb_write && fb_x == 11'd100 && fb_y == 11'd3) && t < 3000) begin
            @(negedge clock);
            t++;
        end
        chk("t5_reached_pixel", fb_write && fb_x == 11'd100 && fb_y == 11'd3, 1);
        reset = 1;
        step();
        chk("t5_write", fb_write, 0);
        chk("t5_busy", busy, 0);
        chk("t5_ready", cmd_ready, 1);
        step();
        reset = 0;
        send('{x0: 11'd1, y0: 11'd2, x1: 11'd3, y1: 11'd4, c: 1'b1});
        step();
        chk("t5_launch", ld_start, 1);
        wait_idle("t5_idle");

        spur_pct = 50;
        spur_seen = 0;
        repeat (30) begin
            @(negedge clock);
            spur_seen += int'(ld_done);
            chk("t6_no_write", fb_write, 0);
            chk("t6_idle", busy, 0);
            chk("t6_no_start", ld_start, 0);
        end
        chk("t6_spurious_driven", spur_seen > 0, 1);
        step();

        spur_pct = 5;
        for (int i = 0; i < 1500; i++) begin
            step();
            if ($urandom_range(0, 2) == 0) begin
                r = cmd_t'(45'({$urandom, $urandom}));
                drive_cmd(r);
            end else cmd_valid = 0;
`ifndef LJS_FLUSH_ON_CLEAR_EN
            chk("rand_ready", cmd_ready, cq.size() < DEPTH);
`endif
            if (cmd_valid && cmd_ready) cq.push_back({cmd_x0, cmd_y0, cmd_x1, cmd_y1, cmd_color});
            if (!outstanding && $urandom_range(0, 299) == 0) begin
                clear_req = 1;
                outstanding = 1;
            end else clear_req = 0;
        end
        step();
        cmd_valid = 0;
        clear_req = 0;
        spur_pct = 0;
        wait_idle("final_idle");
        chk("final_pix_drained", pq.size(), 0);
        chk("final_cmd_drained", cq.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
